// File: rtl/xpm_tdpram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : xpm_tdpram_stream_reader
//  Purpose  : Read-only master for one true-dual-port BRAM port. Turns a
//             (start address, word count) command into a valid/ready stream.
//             The fixed BRAM read latency is hidden behind a small
//             credit-limited output FIFO: full rate under continuous ready
//             and no data loss under backpressure.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              : clock (also BRAM port clock), async active-high reset
//    cmd_valid_i/ready_o   : command handshake
//    cmd_addr_i, cmd_len_i : first word address, word count (0 allowed)
//    addr_o, din_o, en_o,
//    we_o, dout_i          : BRAM port (writes never issued)
//    m_tdata_o/tvalid_o/
//    tready_i/tlast_o      : output stream, tlast on final word of a command
//    done_o                : one-cycle pulse when a command completes
//    busy_o                : high from command accept until done
// ============================================================================
module xpm_tdpram_stream_reader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int LEN_WIDTH    = ADDR_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   din_o,
  output logic                    en_o,
  output logic [DATA_WIDTH/8-1:0] we_o,
  input  logic [DATA_WIDTH-1:0]   dout_i,
  output logic [DATA_WIDTH-1:0]   m_tdata_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic                    m_tlast_o,
  output logic                    done_o,
  output logic                    busy_o
);

  // One extra slot beyond the read latency keeps the pipe full at one word
  // per cycle; the second extra slot absorbs the pop-to-credit delay.
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W:0]     c_DEPTH   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   c_PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0] c_LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    rem_q;

  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [READ_LATENCY-1:0] pipe_last_q;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];
  logic                    last_q [FIFO_DEPTH];

  logic issue, issue_last, push, pop, credit_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit covers both reads in flight in the BRAM and words already queued,
  // so a returning word always finds a free FIFO slot.
  assign credit_ok  = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < c_DEPTH;
  assign issue      = (state_q == S_ISSUE) && credit_ok;
  assign issue_last = issue && (rem_q == c_LEN_ONE);
  assign push       = pipe_vld_q[READ_LATENCY-1];
  assign pop        = m_tvalid_o && m_tready_i;

  assign m_tvalid_o = (fifo_cnt_q != '0);
  assign m_tdata_o  = data_q[rd_ptr_q];
  assign m_tlast_o  = m_tvalid_o && last_q[rd_ptr_q];

  assign cmd_ready_o = cmd_ready_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);
  assign en_o        = issue;
  assign addr_o      = addr_q;
  assign din_o       = '0;
  assign we_o        = '0;

  always_comb begin
    out_cnt_d  = out_cnt_q + CNT_W'(issue) - CNT_W'(push);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Command FSM: state, address, remaining count and registered handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            addr_q <= cmd_addr_i;
            rem_q  <= cmd_len_i;
            if (cmd_len_i == '0) begin
              // Empty command completes without touching the BRAM.
              done_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              cmd_ready_q <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - c_LEN_ONE;
            if (rem_q == c_LEN_ONE) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && m_tlast_o) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Return path and output FIFO. Clearing the issue pipe on reset drops any
  // read still inside the BRAM, so nothing stale reaches the stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      out_cnt_q   <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        data_q[wr_ptr_q] <= dout_i;
        last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xpm_tdpram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xpm_tdpram_stream_reader
//  Purpose  : Directed scoreboard bench for xpm_tdpram_stream_reader with a
//             behavioural BRAM (data = address, latency 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xpm_tdpram_stream_reader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int LW = AW + 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          en;
  logic [DW/8-1:0] we;
  logic [DW-1:0] dout;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          done;
  logic          busy;

  xpm_tdpram_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .addr_o(addr), .din_o(din), .en_o(en), .we_o(we), .dout_i(dout),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tlast_o(m_tlast), .done_o(done), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: data = address, two-cycle read latency, garbage when idle.
  logic [DW-1:0] rd_pipe0 = '0;
  logic [DW-1:0] rd_pipe1 = '0;
  always @(posedge clk) begin
    rd_pipe0 <= en ? {20'h0, addr} : 32'hBAD0_0000;
    rd_pipe1 <= rd_pipe0;
  end
  assign dout = rd_pipe1;

  // Ready pattern driver: mode 0 = always ready, mode 1 = 1,0,0,1 repeating.
  int ready_mode = 0;
  int pk = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) m_tready = 1'b1;
      else                 m_tready = ((pk % 4) == 0) || ((pk % 4) == 3);
      pk++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and observation state.
  logic [32:0] exp_q[$];
  int en_cnt, hs_cnt, busy_cnt, done_cnt, inflight, max_inflight;
  int first_en_cyc, first_hs_cyc, last_hs_cyc, last_done_cyc;
  logic [AW-1:0] first_en_addr;
  logic rdy_at_done, busy_at_done;
  logic stall_prev;
  logic [DW-1:0] prev_data;
  logic prev_last;

  task automatic clr_stats();
    en_cnt = 0; hs_cnt = 0; busy_cnt = 0; inflight = 0; max_inflight = 0;
    first_en_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    first_en_addr = '0;
  endtask

  initial begin
    done_cnt = 0; last_done_cyc = -1; stall_prev = 1'b0;
    rdy_at_done = 1'b0; busy_at_done = 1'b0; prev_data = '0; prev_last = 1'b0;
    clr_stats();
  end

  // Monitor: samples at the falling edge, pops the scoreboard on each beat.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (en) begin
          en_cnt++;
          inflight++;
          if (en_cnt == 1) begin
            first_en_cyc  = cyc;
            first_en_addr = addr;
          end
        end
        if (inflight > max_inflight) max_inflight = inflight;
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
          rdy_at_done   = cmd_ready;
          busy_at_done  = busy;
        end
        if (busy) busy_cnt++;
        if (stall_prev) begin
          chk("hold_valid", m_tvalid, 1);
          chk("hold_data", m_tdata, prev_data);
          chk("hold_last", m_tlast, prev_last);
        end
        if (m_tvalid && m_tready) begin
          hs_cnt++;
          inflight--;
          if (hs_cnt == 1) first_hs_cyc = cyc;
          if (m_tlast) last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e[31:0]);
            chk("beat_last", m_tlast, e[32]);
          end
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Offer a command (caller is just after a rising edge); returns accept cycle.
  task automatic send_cmd(input logic [AW-1:0] a, input int len, output int acc);
    logic [AW-1:0] ad;
    cmd_addr  = a;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got no accept, expected cmd_ready within 300 cycles");
    end else begin
      for (int j = 0; j < len; j++) begin
        ad = a + AW'(j);
        exp_q.push_back({(j == len - 1), 20'h0, ad});
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int seen;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 500 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_we_din"}, {we, din}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, d0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", cmd_ready, 1);
    @(posedge clk);
    #1;

    // 1: full-rate 8-word read from 0x010.
    clr_stats();
    d0 = done_cnt;
    send_cmd(12'h010, 8, acc);
    wait_done(d0);
    chk("t1_first_en_cyc", first_en_cyc - acc, 1);
    chk("t1_first_en_addr", first_en_addr, 12'h010);
    chk("t1_en_cnt", en_cnt, 8);
    chk("t1_first_beat_cyc", first_hs_cyc - acc, 4);
    chk("t1_last_beat_cyc", last_hs_cyc - acc, 11);
    chk("t1_beats", hs_cnt, 8);
    chk("t1_done_cyc", last_done_cyc - acc, 12);
    chk("t1_ready_at_done", rdy_at_done, 1);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 2: same command under 1,0,0,1 backpressure.
    clr_stats();
    ready_mode = 1;
    d0 = done_cnt;
    send_cmd(12'h010, 8, acc);
    wait_done(d0);
    ready_mode = 0;
    chk("t2_en_cnt", en_cnt, 8);
    chk("t2_beats", hs_cnt, 8);
    chk("t2_max_inflight", max_inflight, 4);
    chk("t2_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // 3: address wrap 0xFFE..0x001.
    clr_stats();
    d0 = done_cnt;
    send_cmd(12'hFFE, 4, acc);
    wait_done(d0);
    chk("t3_first_en_addr", first_en_addr, 12'hFFE);
    chk("t3_beats", hs_cnt, 4);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: zero-length command.
    clr_stats();
    d0 = done_cnt;
    send_cmd(12'h050, 0, acc);
    wait_done(d0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_done_cyc", last_done_cyc - acc, 1);
    chk("t4_en_cnt", en_cnt, 0);
    chk("t4_beats", hs_cnt, 0);
    chk("t4_busy_cnt", busy_cnt, 0);

    // 5: reset after 3 beats of a 16-word command.
    clr_stats();
    send_cmd(12'h400, 16, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (hs_cnt >= 3) break;
    end
    chk("t5_beats_before_rst", hs_cnt, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_stats();
    @(posedge clk);
    #1;
    d0 = done_cnt;
    send_cmd(12'h100, 2, acc);
    wait_done(d0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_beats_after_rst", hs_cnt, 2);
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6: back-to-back commands, second offered while busy.
    clr_stats();
    d0 = done_cnt;
    send_cmd(12'h200, 1, acc);
    send_cmd(12'h300, 3, acc2);
    chk("t6_accept_at_done", acc2, last_done_cyc);
    chk("t6_accept_gap", acc2 - acc, 5);
    chk("t6_first_done", done_cnt, d0 + 1);
    d0 = done_cnt;
    wait_done(d0);
    chk("t6_beats", hs_cnt, 4);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xpm_tdpram_stream_reader.md
# xpm_tdpram_stream_reader

Streaming read engine that drives the master side of one true-dual-port BRAM port (`addr`/`din`/`dout`/`en`/`we`) and converts a command (start address, word count) into a valid/ready output stream. It sits directly upstream of the BRAM port: it consumes the BRAM read data and feeds downstream stream consumers such as DMA/TX stages. It hides the fixed BRAM read latency with a credit-limited output FIFO, so it sustains one word per cycle under continuous `m_tready` and never loses data under backpressure.

## Interface
- `ADDR_WIDTH`, default 12: BRAM word-address width.
- `DATA_WIDTH`, default 32: BRAM data width; a multiple of 8.
- `READ_LATENCY`, default 2: cycles from `en` asserted to valid `dout`; legal values 1–3.
- `LEN_WIDTH`, default `ADDR_WIDTH+1`: width of the word-count field.

Ports:
- `clk` in 1: single clock for all logic; also the BRAM port clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_addr` in `ADDR_WIDTH`: first word address.
- `cmd_len` in `LEN_WIDTH`: number of words; 0 is legal.
- `addr` out `ADDR_WIDTH`: BRAM address.
- `din` out `DATA_WIDTH`: BRAM write data; tied to 0.
- `en` out 1: BRAM enable, i.e. read issue.
- `we` out `DATA_WIDTH/8`: BRAM byte write enables; tied to 0.
- `dout` in `DATA_WIDTH`: BRAM read data.
- `m_tdata` out `DATA_WIDTH`: stream data.
- `m_tvalid` out 1: stream valid.
- `m_tready` in 1: stream ready.
- `m_tlast` out 1: marks the final word of a command.
- `done` out 1: one-cycle pulse when a command completes.
- `busy` out 1: high from command accept until `done`.

## Operation
- States:
  - IDLE: `cmd_ready=1`.
  - ISSUE: reads remain to be issued.
  - DRAIN: all reads issued; waiting for the FIFO to empty.
- Transitions:
  - IDLE→ISSUE on `cmd_valid & cmd_ready` with `cmd_len≠0`.
  - IDLE→IDLE on accept with `cmd_len=0`; `done` pulses the next cycle and no read or beat occurs.
  - ISSUE→DRAIN in the cycle the last read is issued.
  - DRAIN→IDLE in the cycle the beat with `m_tlast` handshakes.
- Read issue: `en=1` in a cycle only when in ISSUE and `outstanding + fifo_count < FIFO_DEPTH`.
  - `FIFO_DEPTH = READ_LATENCY + 2`.
  - `outstanding` counts issued reads whose data has not yet been written into the FIFO.
- Address: starts at `cmd_addr` and increments by 1 per issued read. It wraps modulo `2^ADDR_WIDTH`, so 0xFFF→0x000 for the default width.
- Remaining count: loaded with `cmd_len`, decremented per issued read; the last read is issued when it equals 1.
- Return path: a `READ_LATENCY`-deep shift register of issue flags, plus a last flag, writes `dout` into the FIFO exactly `READ_LATENCY` cycles after the matching `en`.
- FIFO write and read in the same cycle are legal, including when the FIFO is full.
- `m_tlast` travels with the data word that belongs to the last issued read.
- `we` and `din` are always 0; the block never writes the BRAM.
- `busy = (state ≠ IDLE)`. A new command is not accepted until the previous `done`.

## Timing
- Reset: asynchronous, effective immediately; all outputs go to 0 (`cmd_ready=0`, `en=0`, `addr=0`, `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `done=0`, `busy=0`).
  - State returns to IDLE and the FIFO, counters and shift register are cleared.
  - `cmd_ready` rises in the first clock edge's cycle after `rst` deasserts.
- Reset mid-command: in-flight BRAM reads are discarded and no stale beat appears after reset.
- Accept is in cycle 0. The first `en` occurs in cycle 1 with `addr=cmd_addr`. Its data enters the FIFO at edge 1+L, and `m_tvalid` is first high in cycle 2+L (L=`READ_LATENCY`).
- With `m_tready` held at 1: one beat per cycle, no bubbles; an N-word command's last beat appears in cycle N+1+L. `done` pulses in the cycle after the last-beat handshake; `cmd_ready` is high in that same cycle.
- With `m_tready=0`: `m_tvalid`, `m_tdata` and `m_tlast` hold stable. Issue stops when credits are exhausted, with at most `FIFO_DEPTH` words buffered and no overflow.
- `m_tvalid` never depends combinationally on `m_tready`.

## Test plan
- `cmd_addr=0x010`, `cmd_len=8`, `m_tready=1`, BRAM preloaded with data=address → `m_tdata` 0x10..0x17 on consecutive cycles. First beat in cycle 4 (L=2), `m_tlast` on 0x17, `done` one cycle later; `en` is high for exactly 8 cycles.
- Same command with `m_tready` toggling 1,0,0,1,… → all 8 words in order, with no duplicates or drops. `en` stalls once 4 words are outstanding or buffered, and output signals stay stable while stalled.
- `cmd_addr=0xFFE`, `cmd_len=4` → addresses 0xFFE, 0xFFF, 0x000, 0x001 are issued and returned in that order.
- `cmd_len=0` → accepted, no `en`, no beat, `done` pulse in the next cycle, `busy` stays 0.
- Assert `rst` with 3 beats delivered of a 16-word command → outputs go to 0 immediately. After release, a command with `cmd_len=2` returns exactly 2 correct beats and no stale words.
- Back-to-back commands (`len`=1, then `len`=3 offered during busy) → the second is accepted only in the cycle of the first `done`. Both streams complete, with `m_tlast` on beat 1 of the first and beat 3 of the second.
